// File: rtl/sync_fifo_param_if.sv
// sync_fifo_param_if: producer/consumer bus of the parametrised FIFO
interface sync_fifo_param_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    localparam int CW = $clog2(DEPTH + 1)
);
    logic [WIDTH-1:0] wr_data;
    logic [WIDTH-1:0] rd_data;
    logic we;
    logic re;
    logic full;
    logic empty;
    logic almost_full;
    logic almost_empty;
    logic overflow;
    logic underflow;
    logic [CW-1:0] count;
    modport master (
        output wr_data, we, re,
        input rd_data, full, empty, almost_full, almost_empty, count, overflow, underflow
    );
    modport slave (
        input wr_data, we, re,
        output rd_data, full, empty, almost_full, almost_empty, count, overflow, underflow
    );
endinterface

// File: rtl/sync_fifo_param.sv
// sync_fifo_param: single-clock FIFO, any depth, status flags and optional first-word-fall-through
module sync_fifo_param #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    parameter int AF_LEVEL = DEPTH - 1,
    parameter int AE_LEVEL = 1,
    parameter int FWFT = 0,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input logic clk,
    input logic rst,
    sync_fifo_param_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [WIDTH-1:0] rd_data_q, rd_data_d;
    logic overflow_q, overflow_d, underflow_q, underflow_d;
    logic rd_ok, wr_ok;
    // A write into a full FIFO is accepted only when a read frees a slot the same cycle
    always_comb begin
        rd_ok = bus.re && count_q != '0;
        wr_ok = bus.we && (count_q != CW'(DEPTH) || rd_ok);
        wr_ptr_d = !wr_ok ? wr_ptr_q : wr_ptr_q == PW'(DEPTH - 1) ? '0 : wr_ptr_q + 1'b1;
        rd_ptr_d = !rd_ok ? rd_ptr_q : rd_ptr_q == PW'(DEPTH - 1) ? '0 : rd_ptr_q + 1'b1;
        count_d = (wr_ok && !rd_ok) ? count_q + 1'b1 : (rd_ok && !wr_ok) ? count_q - 1'b1 : count_q;
        rd_data_d = rd_ok ? mem_q[rd_ptr_q] : rd_data_q;
        overflow_d = overflow_q || (bus.we && !wr_ok);
        underflow_d = underflow_q || (bus.re && !rd_ok);
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q <= '0;
            rd_data_q <= '0;
            overflow_q <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q <= count_d;
            rd_data_q <= rd_data_d;
            overflow_q <= overflow_d;
            underflow_q <= underflow_d;
        end
    end
    always_ff @(posedge clk) begin
        if (!rst && wr_ok) mem_q[wr_ptr_q] <= bus.wr_data;
    end
    assign bus.rd_data = (FWFT != 0) ? mem_q[rd_ptr_q] : rd_data_q;
    assign bus.count = count_q;
    assign bus.full = count_q == CW'(DEPTH);
    assign bus.empty = count_q == '0;
    assign bus.almost_full = count_q >= CW'(AF_LEVEL);
    assign bus.almost_empty = count_q <= CW'(AE_LEVEL);
    assign bus.overflow = overflow_q;
    assign bus.underflow = underflow_q;
endmodule

// File: tb/tb_sync_fifo_param.sv
// tb_sync_fifo_param: directed vectors for the 8-deep, 5-deep and first-word-fall-through configurations
module tb_sync_fifo_param;
    logic clk = 1'b0;
    logic rst_a = 1'b1, rst_b = 1'b1, rst_c = 1'b1;
    int n_chk = 0, n_fail = 0;
    always #5 clk = ~clk;
    sync_fifo_param_if #(.WIDTH(8), .DEPTH(8)) ia ();
    sync_fifo_param_if #(.WIDTH(8), .DEPTH(5)) ib ();
    sync_fifo_param_if #(.WIDTH(8), .DEPTH(8)) ic ();
    sync_fifo_param #(.WIDTH(8), .DEPTH(8), .FWFT(0)) dut_a (.clk(clk), .rst(rst_a), .bus(ia.slave));
    sync_fifo_param #(.WIDTH(8), .DEPTH(5), .FWFT(0)) dut_b (.clk(clk), .rst(rst_b), .bus(ib.slave));
    sync_fifo_param #(.WIDTH(8), .DEPTH(8), .FWFT(1)) dut_c (.clk(clk), .rst(rst_c), .bus(ic.slave));
    typedef struct {
        logic we;
        logic re;
        logic [7:0] din;
        int cnt;
        logic [5:0] fl;
        logic [7:0] rd;
    } vec_t;
    vec_t tbl[18];
    task automatic tick;
        @(posedge clk);
        #1;
    endtask
    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask
    function automatic logic [5:0] flags_a();
        return {ia.full, ia.empty, ia.almost_full, ia.almost_empty, ia.overflow, ia.underflow};
    endfunction
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end
    initial begin
        // flags order: full, empty, almost_full, almost_empty, overflow, underflow
        tbl[0] = '{1'b1, 1'b0, 8'h10, 1, 6'b000100, 8'h00};
        tbl[1] = '{1'b1, 1'b0, 8'h11, 2, 6'b000000, 8'h00};
        tbl[2] = '{1'b1, 1'b0, 8'h12, 3, 6'b000000, 8'h00};
        tbl[3] = '{1'b1, 1'b0, 8'h13, 4, 6'b000000, 8'h00};
        tbl[4] = '{1'b1, 1'b0, 8'h14, 5, 6'b000000, 8'h00};
        tbl[5] = '{1'b1, 1'b0, 8'h15, 6, 6'b000000, 8'h00};
        tbl[6] = '{1'b1, 1'b0, 8'h16, 7, 6'b001000, 8'h00};
        tbl[7] = '{1'b1, 1'b0, 8'h17, 8, 6'b101000, 8'h00};
        tbl[8] = '{1'b1, 1'b0, 8'h18, 8, 6'b101010, 8'h00};
        tbl[9] = '{1'b0, 1'b1, 8'h00, 7, 6'b001010, 8'h10};
        tbl[10] = '{1'b0, 1'b1, 8'h00, 6, 6'b000010, 8'h11};
        tbl[11] = '{1'b0, 1'b1, 8'h00, 5, 6'b000010, 8'h12};
        tbl[12] = '{1'b0, 1'b1, 8'h00, 4, 6'b000010, 8'h13};
        tbl[13] = '{1'b0, 1'b1, 8'h00, 3, 6'b000010, 8'h14};
        tbl[14] = '{1'b0, 1'b1, 8'h00, 2, 6'b000010, 8'h15};
        tbl[15] = '{1'b0, 1'b1, 8'h00, 1, 6'b000110, 8'h16};
        tbl[16] = '{1'b0, 1'b1, 8'h00, 0, 6'b010110, 8'h17};
        tbl[17] = '{1'b0, 1'b1, 8'h00, 0, 6'b010111, 8'h17};
        {ia.we, ia.re, ia.wr_data} = '0;
        {ib.we, ib.re, ib.wr_data} = '0;
        {ic.we, ic.re, ic.wr_data} = '0;
        tick;
        tick;
        rst_a = 1'b0;
        rst_b = 1'b0;
        rst_c = 1'b0;
        chk("reset_count", int'(ia.count), 0);
        chk("reset_flags", int'(flags_a()), 6'b010100);
        chk("reset_rd_data", int'(ia.rd_data), 0);
        for (int i = 0; i < 18; i++) begin
            ia.we = tbl[i].we;
            ia.re = tbl[i].re;
            ia.wr_data = tbl[i].din;
            tick;
            chk($sformatf("vec%0d_count", i), int'(ia.count), tbl[i].cnt);
            chk($sformatf("vec%0d_flags", i), int'(flags_a()), int'(tbl[i].fl));
            chk($sformatf("vec%0d_rd_data", i), int'(ia.rd_data), int'(tbl[i].rd));
        end
        // full boundary: simultaneous access keeps the FIFO full without overflow
        ia.we = 1'b0;
        ia.re = 1'b0;
        rst_a = 1'b1;
        tick;
        rst_a = 1'b0;
        ia.we = 1'b1;
        for (int i = 0; i < 8; i++) begin
            ia.wr_data = 8'(8'h20 + i);
            tick;
        end
        ia.re = 1'b1;
        ia.wr_data = 8'h28;
        tick;
        chk("full_rw_count", int'(ia.count), 8);
        chk("full_rw_overflow", int'(ia.overflow), 0);
        chk("full_rw_rd_data", int'(ia.rd_data), 8'h20);
        ia.we = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick;
            chk($sformatf("full_rw_drain%0d", i), int'(ia.rd_data), 8'h21 + i);
        end
        chk("drained_empty", int'(ia.empty), 1);
        // empty boundary: read rejected, write accepted
        ia.we = 1'b1;
        ia.wr_data = 8'h30;
        tick;
        chk("empty_rw_count", int'(ia.count), 1);
        chk("empty_rw_underflow", int'(ia.underflow), 1);
        chk("empty_rw_rd_hold", int'(ia.rd_data), 8'h28);
        ia.we = 1'b0;
        tick;
        chk("empty_rw_readback", int'(ia.rd_data), 8'h30);
        chk("empty_rw_count_after", int'(ia.count), 0);
        ia.re = 1'b0;
        ia.we = 1'b1;
        for (int i = 0; i < 9; i++) begin
            ia.wr_data = 8'(8'h50 + i);
            tick;
        end
        ia.we = 1'b0;
        ia.re = 1'b1;
        for (int i = 0; i < 4; i++) tick;
        ia.re = 1'b0;
        chk("pre_reset_count", int'(ia.count), 4);
        chk("pre_reset_overflow", int'(ia.overflow), 1);
        rst_a = 1'b1;
        ia.we = 1'b1;
        ia.wr_data = 8'h99;
        tick;
        rst_a = 1'b0;
        ia.we = 1'b0;
        chk("midrst_count", int'(ia.count), 0);
        chk("midrst_flags", int'(flags_a()), 6'b010100);
        chk("midrst_rd_data", int'(ia.rd_data), 0);
        tick;
        chk("midrst_write_ignored", int'(ia.count), 0);
        // DEPTH=5: steady streaming at count=2 wraps both pointers four times
        ib.we = 1'b1;
        ib.wr_data = 8'h40;
        tick;
        ib.wr_data = 8'h41;
        tick;
        ib.re = 1'b1;
        for (int i = 0; i < 20; i++) begin
            ib.wr_data = 8'(8'h42 + i);
            tick;
            chk($sformatf("wrap%0d_rd_data", i), int'(ib.rd_data), 8'h40 + i);
            chk($sformatf("wrap%0d_count", i), int'(ib.count), 2);
        end
        ib.we = 1'b0;
        ib.re = 1'b0;
        chk("wrap_overflow", int'(ib.overflow), 0);
        chk("wrap_underflow", int'(ib.underflow), 0);
        // first-word-fall-through
        ic.we = 1'b1;
        ic.wr_data = 8'hA5;
        tick;
        ic.we = 1'b0;
        chk("fwft_head", int'(ic.rd_data), 8'hA5);
        chk("fwft_not_empty", int'(ic.empty), 0);
        ic.we = 1'b1;
        ic.wr_data = 8'h3C;
        tick;
        ic.we = 1'b0;
        chk("fwft_head_held", int'(ic.rd_data), 8'hA5);
        chk("fwft_count2", int'(ic.count), 2);
        ic.re = 1'b1;
        tick;
        chk("fwft_next", int'(ic.rd_data), 8'h3C);
        chk("fwft_count1", int'(ic.count), 1);
        tick;
        ic.re = 1'b0;
        chk("fwft_empty", int'(ic.empty), 1);
        chk("fwft_underflow", int'(ic.underflow), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
